// File: rtl/ex_if.sv
// ex_if: ID/EX inputs, forwarding selects and EX/MEM outputs of the execute stage.
interface ex_if #(parameter int XLEN = 32);
    logic            stall;
    logic            flush;
    logic            id_ex_valid;
    logic [XLEN-1:0] id_ex_rs1_data;
    logic [XLEN-1:0] id_ex_rs2_data;
    logic [XLEN-1:0] id_ex_imm;
    logic [4:0]      id_ex_rd;
    logic [3:0]      id_ex_alu_ctrl;
    logic            id_ex_alusrc;
    logic            id_ex_regwrite;
    logic            id_ex_memread;
    logic            id_ex_memwrite;
    logic            id_ex_memtoreg;
    logic [1:0]      forwardA;
    logic [1:0]      forwardB;
    logic [XLEN-1:0] wb_data;
    logic            alu_zero;
    logic            ex_mem_valid;
    logic [XLEN-1:0] ex_mem_alu_result;
    logic [XLEN-1:0] ex_mem_store_data;
    logic [4:0]      ex_mem_rd;
    logic            ex_mem_regwrite;
    logic            ex_mem_memread;
    logic            ex_mem_memwrite;
    logic            ex_mem_memtoreg;
    modport master (
        output stall, flush, id_ex_valid, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_rd,
               id_ex_alu_ctrl, id_ex_alusrc, id_ex_regwrite, id_ex_memread, id_ex_memwrite,
               id_ex_memtoreg, forwardA, forwardB, wb_data,
        input  alu_zero, ex_mem_valid, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd,
               ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite, ex_mem_memtoreg
    );
    modport slave (
        input  stall, flush, id_ex_valid, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_rd,
               id_ex_alu_ctrl, id_ex_alusrc, id_ex_regwrite, id_ex_memread, id_ex_memwrite,
               id_ex_memtoreg, forwardA, forwardB, wb_data,
        output alu_zero, ex_mem_valid, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd,
               ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite, ex_mem_memtoreg
    );
endinterface

// File: rtl/execute_stage.sv
// execute_stage: forwarding operand muxes, ALU and the EX/MEM pipeline register.
module execute_stage #(parameter int XLEN = 32) (
    input logic clk,
    input logic reset,
    ex_if.slave ex
);
    localparam int SW = $clog2(XLEN);
    localparam int QW = 2 * XLEN + 10;
    logic [XLEN-1:0] op_a, fwd_b, op_b, result;
    logic [SW-1:0]   shamt;
    logic [QW-1:0]   d, q;
    assign op_a  = ex.forwardA == 2'b10 ? ex.ex_mem_alu_result :
                   ex.forwardA == 2'b01 ? ex.wb_data : ex.id_ex_rs1_data;
    assign fwd_b = ex.forwardB == 2'b10 ? ex.ex_mem_alu_result :
                   ex.forwardB == 2'b01 ? ex.wb_data : ex.id_ex_rs2_data;
    assign op_b  = ex.id_ex_alusrc ? ex.id_ex_imm : fwd_b;
    assign shamt = op_b[SW-1:0];
    always_comb begin
        result = '0;
        case (ex.id_ex_alu_ctrl)
            4'b0000: result = op_a & op_b;
            4'b0001: result = op_a | op_b;
            4'b0010: result = op_a + op_b;
            4'b0011: result = op_a ^ op_b;
            4'b0100: result = op_a << shamt;
            4'b0101: result = op_a >> shamt;
            4'b0110: result = op_a - op_b;
            4'b0111: result = XLEN'($signed(op_a) < $signed(op_b));
            4'b1000: result = XLEN'(op_a < op_b);
            4'b1001: result = $signed(op_a) >>> shamt;
            default: result = '0;
        endcase
    end
    assign ex.alu_zero = result == '0;
    // An invalid instruction still carries its data, but its control enters as a bubble.
    assign d = {ex.id_ex_valid, result, fwd_b, ex.id_ex_rd,
                {ex.id_ex_regwrite, ex.id_ex_memread, ex.id_ex_memwrite, ex.id_ex_memtoreg} & {4{ex.id_ex_valid}}};
    always_ff @(posedge clk or posedge reset)
        if (reset)
            q <= '0;
        else if (ex.flush)
            q <= '0;
        else if (!ex.stall)
            q <= d;
    assign {ex.ex_mem_valid, ex.ex_mem_alu_result, ex.ex_mem_store_data, ex.ex_mem_rd,
            ex.ex_mem_regwrite, ex.ex_mem_memread, ex.ex_mem_memwrite, ex.ex_mem_memtoreg} = q;
endmodule
